uart_tx_fifo: RTL and testbench

Buffered 8-bit UART transmitter for the CPU's serial link back to the host. It is the outbound counterpart of the receiver on Rx.
- Core-side byte writes enter a small synchronous FIFO.
- A frame engine drains the FIFO and serialises each byte onto tx as start / 8 data LSB-first / optional parity / 1 stop.
- Sits between the memory-mapped I/O controller and the top-level Tx pin.

---
 rtl/uart_tx_fifo.sv | 135 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8-bit UART transmitter: byte FIFO feeding a start/data/parity/stop
// frame engine with back-to-back frames and no idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int PARITY          = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [FIFO_DEPTH_LOG2:0] count,
  output logic                     tx,
  output logic                     busy,
  output logic                     tx_done
);

  localparam int L     = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << L;
  localparam int BW    = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t          state;
  logic [BW-1:0]   baud;
  logic [2:0]      bitidx;
  logic [7:0]      shift;
  logic            par;

  logic [7:0]      mem [DEPTH];
  logic [L-1:0]    wptr;
  logic [L-1:0]    rptr;
  logic [L:0]      cnt_n;
  logic            wr_ok;
  logic            pop;
  logic            last;
  logic [7:0]      head;

  always_comb begin
    last  = (baud == BW'(CLKS_PER_BIT - 1));
    wr_ok = wr_en && !full;
    pop   = !empty && ((state == S_IDLE) || (state == S_STOP && last));
    head  = mem[rptr];
    cnt_n = count + {{L{1'b0}}, wr_ok} - {{L{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr_ok) wptr <= wptr + L'(1);
      if (pop)   rptr <= rptr + L'(1);
      count <= cnt_n;
      full  <= (cnt_n == (L+1)'(DEPTH));
      empty <= (cnt_n == '0);
    end
  end

  // Outputs are registered from the current state, so tx trails state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      baud    <= '0;
      bitidx  <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx      <= (state == S_START) ? 1'b0 :
                 (state == S_DATA)  ? shift[0] :
                 (state == S_PAR)   ? par : 1'b1;
      busy    <= (state != S_IDLE);
      tx_done <= (state == S_STOP) && last;
      baud    <= last ? '0 : baud + BW'(1);
      unique case (state)
        S_IDLE: begin
          baud <= '0;
          if (pop) begin
            shift <= head;
            par   <= (^head) ^ (PARITY == 2);
            state <= S_START;
          end
        end
        S_START: begin
          if (last) begin
            bitidx <= '0;
            state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (last) begin
            shift  <= shift >> 1;
            bitidx <= bitidx + 3'd1;
            if (bitidx == 3'd7)
              state <= (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
        S_PAR: begin
          if (last) state <= S_STOP;
        end
        S_STOP: begin
          if (last) begin
            if (pop) begin
              shift <= head;
              par   <= (^head) ^ (PARITY == 2);
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed steps, tx-line decoder with a byte
// scoreboard, plus even/odd parity instances.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en0 = 1'b0;
  logic [7:0] wr_data0 = '0;
  logic       full0, empty0, tx0, busy0, tx_done0;
  logic [3:0] count0;

  logic       wr_enp = 1'b0;
  logic [7:0] wr_datap = '0;
  logic       full1, empty1, tx1, busy1, tx_done1;
  logic       full2, empty2, tx2, busy2, tx_done2;
  logic [3:0] count1, count2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] q[$];
  int         starts[$];
  logic       mon_en = 1'b1;
  logic [9:0] m_f;
  logic       m_ab;
  logic [7:0] m_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(3), .PARITY(0)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_data(wr_data0),
    .full(full0), .empty(empty0), .count(count0),
    .tx(tx0), .busy(busy0), .tx_done(tx_done0)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(3), .PARITY(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_enp), .wr_data(wr_datap),
    .full(full1), .empty(empty1), .count(count1),
    .tx(tx1), .busy(busy1), .tx_done(tx_done1)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(3), .PARITY(2)) u2 (
    .clk(clk), .rst(rst), .wr_en(wr_enp), .wr_data(wr_datap),
    .full(full2), .empty(empty2), .count(count2),
    .tx(tx2), .busy(busy2), .tx_done(tx_done2)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en0   = 1'b1;
    wr_data0 = d;
    step();
    wr_en0   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(busy0 === 1'b0 && empty0 === 1'b1 && q.size() == 0) && n < 3000) begin
      step();
      n++;
    end
    check(tag, (n < 3000), 1);
    repeat (2) step();
  endtask

  // Line decoder: samples mid-bit on negedges, compares against the scoreboard.
  always begin
    @(negedge clk);
    if (mon_en && !rst && tx0 === 1'b0) begin
      m_ab = 1'b0;
      starts.push_back(cyc);
      for (int b = 0; b < 10; b++) begin
        repeat ((b == 0) ? 2 : 4) @(negedge clk);
        if (rst || !mon_en) begin
          m_ab = 1'b1;
          break;
        end
        m_f[b] = tx0;
      end
      if (!m_ab) begin
        @(negedge clk);
        if (!rst && mon_en) begin
          check("mon_start_bit", m_f[0], 0);
          check("mon_stop_bit", m_f[9], 1);
          check("mon_tx_done", tx_done0, 1);
          check("mon_expected_frame", (q.size() != 0), 1);
          if (q.size() != 0) begin
            m_exp = q.pop_front();
            check("mon_byte", m_f[8:1], m_exp);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic       exp_bit;
    logic       bad;

    // Reset state
    step();
    step();
    check("rst_tx", tx0, 1);
    check("rst_busy", busy0, 0);
    check("rst_tx_done", tx_done0, 0);
    check("rst_full", full0, 0);
    check("rst_empty", empty0, 1);
    check("rst_count", count0, 0);
    rst = 1'b0;
    step();

    // Single byte 0x55 with cycle-exact line check
    d = 8'h55;
    q.push_back(d);
    wr(d);
    check("t1_empty", empty0, 0);
    check("t1_count", count0, 1);
    step();
    check("t1_tx_before_start", tx0, 1);
    step();
    for (int off = 0; off < 40; off++) begin
      if (off < 4)       exp_bit = 1'b0;
      else if (off < 36) exp_bit = d[(off - 4) / 4];
      else               exp_bit = 1'b1;
      check($sformatf("t1_tx_off%0d", off), tx0, exp_bit);
      check($sformatf("t1_done_off%0d", off), tx_done0, (off == 39));
      step();
    end
    wait_idle("t1_idle");
    check("t1_end_busy", busy0, 0);
    check("t1_end_count", count0, 0);

    // Back-to-back frames
    starts.delete();
    q.push_back(8'hA3);
    q.push_back(8'h3C);
    wr(8'hA3);
    wr(8'h3C);
    wait_idle("b2b_idle");
    check("b2b_frames", starts.size(), 2);
    if (starts.size() == 2)
      check("b2b_spacing", starts[1] - starts[0], 40);

    // Ten consecutive writes: first pops early, FIFO fills, last is dropped
    starts.delete();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) q.push_back(8'(i));
      wr(8'(i));
      if (i == 8) begin
        check("fill_count8", count0, 8);
        check("fill_full", full0, 1);
      end
      if (i == 9) check("fill_drop_count", count0, 8);
    end
    wait_idle("fill_idle");
    check("fill_frames", starts.size(), 9);

    // Full FIFO with a write in the exact pop cycle
    q.push_back(8'h11);
    wr(8'h11);
    for (int i = 0; i < 8; i++) begin
      q.push_back(8'(8'h20 + i));
      wr(8'(8'h20 + i));
    end
    check("fp_full", full0, 1);
    check("fp_count8", count0, 8);
    wr(8'h99);
    check("fp_drop_count", count0, 8);
    repeat (31) step();
    wr(8'hEE);
    check("fp_pop_count", count0, 7);
    check("fp_pop_full", full0, 0);
    check("fp_pop_done", tx_done0, 1);
    wait_idle("fp_idle");

    // Reset during data bit 3 with bytes queued
    wr(8'h81);
    wr(8'h82);
    wr(8'h83);
    repeat (17) step();
    check("mr_tx_low_bit3", tx0, 0);
    mon_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    check("mr_tx", tx0, 1);
    check("mr_busy", busy0, 0);
    check("mr_count", count0, 0);
    check("mr_empty", empty0, 1);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx0 !== 1'b1 || busy0 !== 1'b0) bad = 1'b1;
    end
    check("mr_no_frames", bad, 0);
    mon_en = 1'b1;

    // Parity instances: 0x07 -> even parity 1, odd parity 0, 44-cycle frame
    wr_enp   = 1'b1;
    wr_datap = 8'h07;
    step();
    wr_enp   = 1'b0;
    step();
    check("par_tx1_idle", tx1, 1);
    step();
    check("par_tx1_start", tx1, 0);
    check("par_tx2_start", tx2, 0);
    repeat (6) step();
    check("par_tx1_d0", tx1, 1);
    repeat (32) step();
    check("par_even_bit", tx1, 1);
    check("par_odd_bit", tx2, 0);
    repeat (4) step();
    check("par_done1_early", tx_done1, 0);
    step();
    check("par_done1", tx_done1, 1);
    check("par_done2", tx_done2, 1);
    check("par_stop1", tx1, 1);
    step();
    check("par_busy1_end", busy1, 0);
    check("par_busy2_end", busy2, 0);
    check("par_done1_clear", tx_done1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
